// File: rtl/bits_to_symbol.sv
// Serial-to-symbol packer: gathers bits into SYMBOL_W-bit symbols, pads partial
// symbols at frame end, and buffers them in a small FIFO for the chip spreader.
module bits_to_symbol #(
  parameter int SYMBOL_W   = 4,
  parameter int FIFO_DEPTH = 2,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_bit,
  input  logic                i_bit_valid,
  input  logic                i_frame_end,
  output logic                o_bit_ready,
  output logic [SYMBOL_W-1:0] o_symbol,
  output logic                o_symbol_valid,
  output logic                o_symbol_last,
  output logic                o_symbol_pad,
  input  logic                i_symbol_read,
  output logic                o_overflow
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;
  localparam int BC_W  = $clog2(SYMBOL_W);

  logic [SYMBOL_W-1:0] sr_q, sr_d;
  logic [BC_W-1:0]     cnt_q, cnt_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]    occ_q, occ_d;
  logic                ovf_q, ovf_d;
  logic [SYMBOL_W-1:0] mem_sym_q  [FIFO_DEPTH];
  logic [SYMBOL_W-1:0] mem_sym_d  [FIFO_DEPTH];
  logic                mem_last_q [FIFO_DEPTH];
  logic                mem_last_d [FIFO_DEPTH];
  logic                mem_pad_q  [FIFO_DEPTH];
  logic                mem_pad_d  [FIFO_DEPTH];

  logic                full, empty, accept, pop, push, complete;
  logic [SYMBOL_W-1:0] sr_shift, sym_new;
  logic [BC_W-1:0]     pad_amt;

  always_comb begin
    full     = (occ_q == OCC_W'(FIFO_DEPTH));
    empty    = (occ_q == '0);
    accept   = i_bit_valid & ~full;
    pop      = i_symbol_read & ~empty;
    complete = (cnt_q == BC_W'(SYMBOL_W - 1));
    push     = accept & (complete | i_frame_end);

    if (MSB_FIRST) sr_shift = {sr_q[SYMBOL_W-2:0], i_bit};
    else           sr_shift = {i_bit, sr_q[SYMBOL_W-1:1]};

    // Shifting by the number of missing bits discards stale bits from the
    // previous symbol and zero-fills the pad positions; it is 0 on completion.
    pad_amt = BC_W'(SYMBOL_W - 1) - cnt_q;
    if (MSB_FIRST) sym_new = sr_shift << pad_amt;
    else           sym_new = sr_shift >> pad_amt;

    sr_d       = sr_q;
    cnt_d      = cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    ovf_d      = ovf_q | (i_bit_valid & full);
    mem_sym_d  = mem_sym_q;
    mem_last_d = mem_last_q;
    mem_pad_d  = mem_pad_q;

    if (accept) begin
      sr_d  = sr_shift;
      cnt_d = push ? '0 : cnt_q + BC_W'(1);
    end

    if (push) begin
      mem_sym_d[wr_ptr_q]  = sym_new;
      mem_last_d[wr_ptr_q] = i_frame_end;
      mem_pad_d[wr_ptr_q]  = ~complete;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end

    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sr_q       <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      ovf_q      <= 1'b0;
      mem_sym_q  <= '{default: '0};
      mem_last_q <= '{default: 1'b0};
      mem_pad_q  <= '{default: 1'b0};
    end else begin
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      ovf_q      <= ovf_d;
      mem_sym_q  <= mem_sym_d;
      mem_last_q <= mem_last_d;
      mem_pad_q  <= mem_pad_d;
    end
  end

  always_comb begin
    o_bit_ready    = ~full;
    o_symbol_valid = ~empty;
    o_overflow     = ovf_q;
    o_symbol       = empty ? '0 : mem_sym_q[rd_ptr_q];
    o_symbol_last  = empty ? 1'b0 : mem_last_q[rd_ptr_q];
    o_symbol_pad   = empty ? 1'b0 : mem_pad_q[rd_ptr_q];
  end

endmodule
